// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request-decode helpers for the load/store sequencer.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } LsuState;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes; encodings 011/11x only reach here as errors and map to 4.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  // Stores have no unsigned variants; loads accept the five RV32 encodings.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign- or zero-extends an assembled load value from its access size to 32 bits.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  // Byte and half results take their upper bits from the sign bit or zeros; words pass through.
  always_comb begin
    result = raw;
    if (size == 3'd1) begin
      result = is_unsigned ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
    end else if (size == 3'd2) begin
      result = is_unsigned ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
    end
  end

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer: accepts one RV32 access, splits it into BEAT_BYTES-wide memory
// beats, assembles and extends load data, and returns a one-cycle response.
// Handshakes: a request is accepted on a rising edge with req_valid && req_ready; a memory
// beat completes on a rising edge with mem_valid && mem_ready, and mem_* stay stable until
// then; rsp_valid is a single-cycle pulse with no backpressure.
module lsu_seq
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int XLEN       = 32,
  parameter int BEAT_BYTES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_is_store,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [XLEN-1:0]         req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_error,
  output logic [XLEN-1:0]         rsp_rdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [BEAT_BYTES-1:0]   mem_wstrb,
  output logic [8*BEAT_BYTES-1:0] mem_wdata,
  input  logic [8*BEAT_BYTES-1:0] mem_rdata,
  output logic [1:0]              dbg_state
);

  localparam int BW = 8 * BEAT_BYTES;

  LsuState                state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [2:0]             f3_q, f3_d;
  logic                   store_q, store_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic [31:0]            asm_q, asm_d;
  logic                   mem_valid_q, mem_valid_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [BEAT_BYTES-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic [BW-1:0]          mem_wdata_q, mem_wdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_error_q, rsp_error_d;
  logic [XLEN-1:0]        rsp_rdata_q, rsp_rdata_d;

  logic [2:0]  size_q;
  logic [2:0]  req_size;
  logic        req_err;
  logic [2:0]  last_idx;
  logic [31:0] ext_value;

  // Beat address: BEAT_BYTES-aligned base of the access plus idx whole beats.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0] idx);
    return (a & ~ADDR_W'(BEAT_BYTES - 1)) + ADDR_W'(int'(idx) * BEAT_BYTES);
  endfunction

  // Lanes touched by beat idx: byte k lives in beat k/BEAT_BYTES on lane (addr+k)%BEAT_BYTES.
  function automatic logic [BEAT_BYTES-1:0] beat_strb(input logic [1:0] lo,
                                                      input logic [2:0] size,
                                                      input logic [2:0] idx);
    logic [BEAT_BYTES-1:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(size) && (k / BEAT_BYTES) == int'(idx)) s[(int'(lo) + k) % BEAT_BYTES] = 1'b1;
    end
    return s;
  endfunction

  // Write lanes for beat idx; lanes without a strobe stay zero.
  function automatic logic [BW-1:0] beat_data(input logic [1:0] lo, input logic [2:0] size,
                                              input logic [2:0] idx, input logic [31:0] wd);
    logic [BW-1:0] d;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(size) && (k / BEAT_BYTES) == int'(idx))
        d[8 * ((int'(lo) + k) % BEAT_BYTES) +: 8] = wd[8 * k +: 8];
    end
    return d;
  endfunction

  assign size_q   = access_size(f3_q);
  assign req_size = access_size(req_funct3);
  assign req_err  = !funct3_legal(req_is_store, req_funct3) ||
                    ((req_addr[1:0] & 2'(req_size - 3'd1)) != 2'b00);
  assign last_idx = (int'(size_q) > BEAT_BYTES) ? 3'(int'(size_q) / BEAT_BYTES - 1) : 3'd0;

  lsu_extend u_extend (
    .raw         (asm_q),
    .size        (size_q),
    .is_unsigned (f3_q[2]),
    .result      (ext_value)
  );

  // Next-state, beat sequencing, load assembly and response formation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    f3_d        = f3_q;
    store_d     = store_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    asm_d       = asm_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          store_d = req_is_store;
          wdata_d = req_wdata;
          err_d   = req_err;
          cnt_d   = 3'd0;
          asm_d   = 32'h0;
          if (req_err) begin
            state_d = RESP;
          end else begin
            state_d     = BEAT;
            mem_valid_d = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = beat_addr(req_addr, 3'd0);
            mem_wstrb_d = req_is_store ? beat_strb(req_addr[1:0], req_size, 3'd0) : '0;
            mem_wdata_d = req_is_store ? beat_data(req_addr[1:0], req_size, 3'd0, req_wdata) : '0;
          end
        end
      end
      BEAT: begin
        if (mem_valid_q && mem_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (!store_q) begin
            for (int k = 0; k < 4; k++) begin
              if (k < int'(size_q) && (k / BEAT_BYTES) == int'(cnt_q))
                asm_d[8 * k +: 8] = mem_rdata[8 * ((int'(addr_q[1:0]) + k) % BEAT_BYTES) +: 8];
            end
          end
          if (cnt_q == last_idx) begin
            state_d     = RESP;
            mem_valid_d = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wstrb_d = '0;
            mem_wdata_d = '0;
          end else begin
            mem_addr_d  = beat_addr(addr_q, cnt_q + 3'd1);
            mem_wstrb_d = store_q ? beat_strb(addr_q[1:0], size_q, cnt_q + 3'd1) : '0;
            mem_wdata_d = store_q ? beat_data(addr_q[1:0], size_q, cnt_q + 3'd1, wdata_q) : '0;
          end
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_error_d = err_q;
        rsp_rdata_d = (!store_q && !err_q) ? XLEN'(ext_value) : '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      f3_q        <= 3'd0;
      store_q     <= 1'b0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      asm_q       <= 32'h0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      f3_q        <= f3_d;
      store_q     <= store_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      asm_q       <= asm_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign dbg_state = state_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Bench for lsu_seq: three instances with 1-, 2- and 4-byte memory ports share one byte memory.
module tb_lsu_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [2:0]        req_valid, mem_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic [2:0]        req_ready_v, rsp_valid_v, rsp_error_v, mem_valid_v, mem_we_v;
  logic [2:0][31:0]  rsp_rdata_v, mem_addr_v, mem_wdata_v;
  logic [2:0][3:0]   mem_wstrb_v;
  logic [2:0][1:0]   dbg_v;
  logic [7:0]        mem [256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BB = 1 << g;
    logic [BB-1:0]   strb;
    logic [8*BB-1:0] wd, rd;
    lsu_seq #(.ADDR_W(32), .XLEN(32), .BEAT_BYTES(BB)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready_v[g]),
      .req_is_store(req_is_store), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_v[g]), .rsp_error(rsp_error_v[g]), .rsp_rdata(rsp_rdata_v[g]),
      .mem_valid(mem_valid_v[g]), .mem_ready(mem_ready[g]), .mem_we(mem_we_v[g]),
      .mem_addr(mem_addr_v[g]), .mem_wstrb(strb), .mem_wdata(wd), .mem_rdata(rd),
      .dbg_state(dbg_v[g])
    );
    assign mem_wstrb_v[g] = 4'(strb);
    assign mem_wdata_v[g] = 32'(wd);
    // Memory read lanes follow the presented beat address.
    always_comb begin
      rd = '0;
      for (int j = 0; j < BB; j++) rd[8*j +: 8] = mem[8'(mem_addr_v[g][7:0] + 8'(j))];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        chk_w;
  } beat_t;

  beat_t       beat_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] addr_log[$], wd_log[$];
  logic [3:0]  strb_log[$];
  int n_cmp = 0, n_fail = 0, cur = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: derive beats and the response from the access rules and the byte memory.
  task automatic build_expect(input int d, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic err, output int nb);
    int bb, size, lane;
    logic legal;
    logic [31:0] val, a;
    beat_t b;
    bb   = 1 << d;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err  = !legal || (addr % size != 0);
    nb   = err ? 0 : ((size > bb) ? size / bb : 1);
    for (int i = 0; i < nb; i++) begin
      b.addr = (addr / bb) * bb + i * bb;
      b.we = st; b.strb = 4'h0; b.wdata = 32'h0; b.chk_w = st;
      for (int k = 0; k < size; k++) begin
        if (k / bb == i) begin
          lane = (addr + k) % bb;
          b.strb[lane] = 1'b1;
          b.wdata[8*lane +: 8] = wd[8*k +: 8];
        end
      end
      beat_q.push_back(b);
    end
    val = 32'h0;
    if (!st && !err) begin
      for (int k = 0; k < size; k++) begin
        a = addr + k;
        val = val | (32'(mem[a[7:0]]) << (8 * k));
      end
      if (size < 4 && !f3[2] && val[8*size-1]) val = val | ~((32'h1 << (8 * size)) - 1);
    end
    exp_q.push_back({err, val});
  endtask

  // Compare process: every beat and response against the model's queues.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (mem_valid_v[d]) begin
          if (d != cur || beat_q.size() == 0) begin
            check("beat_unexpected", 32'(mem_valid_v[d]), 32'h0);
          end else begin
            check("mem_addr", mem_addr_v[d], beat_q[0].addr);
            check("mem_we", 32'(mem_we_v[d]), 32'(beat_q[0].we));
            if (beat_q[0].chk_w) begin
              check("mem_wstrb", 32'(mem_wstrb_v[d]), 32'(beat_q[0].strb));
              check("mem_wdata", mem_wdata_v[d], beat_q[0].wdata);
            end
            if (mem_ready[d]) begin
              addr_log.push_back(mem_addr_v[d]);
              strb_log.push_back(mem_wstrb_v[d]);
              wd_log.push_back(mem_wdata_v[d]);
              void'(beat_q.pop_front());
            end
          end
        end
        if (rsp_valid_v[d]) begin
          if (d != cur || exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid_v[d]), 32'h0);
          end else begin
            check("rsp_error", 32'(rsp_error_v[d]), 32'(exp_q[0][32]));
            check("rsp_rdata", rsp_rdata_v[d], exp_q[0][31:0]);
            void'(exp_q.pop_front());
          end
        end else begin
          check("rsp_error_idle", 32'(rsp_error_v[d]), 32'h0);
          check("rsp_rdata_idle", rsp_rdata_v[d], 32'h0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input int d, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int stall,
                           output logic [31:0] rdata, output logic err_o, output int lat);
    logic err;
    int nb;
    bit seen;
    @(posedge clk); #1;
    cur = d;
    addr_log.delete(); strb_log.delete(); wd_log.delete();
    build_expect(d, st, f3, addr, wd, err, nb);
    req_valid[d] = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    mem_ready[d] = (stall == 0);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    req_funct3 = 3'($urandom_range(0, 7)); req_is_store = 1'($urandom_range(0, 1));
    lat = 0; seen = 0; rdata = 32'h0; err_o = 1'b0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == stall) mem_ready[d] = 1'b1;
      if (rsp_valid_v[d]) begin
        seen = 1; rdata = rsp_rdata_v[d]; err_o = rsp_error_v[d];
      end
    end
    mem_ready[d] = 1'b1;
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid from dut %0d within 60 cycles", d);
    end
    check("latency", 32'(lat), err ? 32'd1 : 32'(nb + 1 + stall));
    @(negedge clk); #1;
    check("beats_left", 32'(beat_q.size()), 32'h0);
    check("rsp_left", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    logic er;
    int lat, nb;
    logic e;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h80] = 8'h58;
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h80;
    rst = 1'b1; req_valid = 3'b000; mem_ready = 3'b111;
    req_is_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_req_ready", 32'(req_ready_v[d]), 32'h1);
      check("rst_mem_valid", 32'(mem_valid_v[d]), 32'h0);
      check("rst_mem_we", 32'(mem_we_v[d]), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid_v[d]), 32'h0);
      check("rst_mem_addr", mem_addr_v[d], 32'h0);
      check("rst_mem_wstrb", 32'(mem_wstrb_v[d]), 32'h0);
      check("rst_mem_wdata", mem_wdata_v[d], 32'h0);
      check("rst_rsp_rdata", rsp_rdata_v[d], 32'h0);
    end
    rst = 1'b0;

    // LW over a byte port: four beats, five cycles to response.
    do_access(0, 1'b0, 3'b010, 32'h80, 32'h0, 0, rd, er, lat);
    check("lw_b1_rdata", rd, 32'h00000058);
    check("lw_b1_lat", 32'(lat), 32'd5);
    check("lw_b1_nbeats", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check("lw_b1_beat_addr", addr_log[i], 32'h80 + 32'(i));

    // Reset during beat 2 of an LW abandons it without a response.
    cur = 0;
    build_expect(0, 1'b0, 3'b010, 32'h80, 32'h0, e, nb);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_beat2_addr", mem_addr_v[0], 32'h82);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_mem_valid", 32'(mem_valid_v[0]), 32'h0);
    check("rst_mid_req_ready", 32'(req_ready_v[0]), 32'h1);
    check("rst_mid_rsp_valid", 32'(rsp_valid_v[0]), 32'h0);
    beat_q.delete(); exp_q.delete();
    rst = 1'b0;
    repeat (8) @(posedge clk);
    do_access(0, 1'b0, 3'b010, 32'h80, 32'h0, 0, rd, er, lat);
    check("lw_after_rst", rd, 32'h00000058);

    // Signed and unsigned byte loads.
    mem[8'h81] = 8'h9C;
    do_access(0, 1'b0, 3'b000, 32'h81, 32'h0, 0, rd, er, lat);
    check("lb_rdata", rd, 32'hFFFFFF9C);
    check("lb_nbeats", 32'(addr_log.size()), 32'd1);
    do_access(0, 1'b0, 3'b100, 32'h81, 32'h0, 0, rd, er, lat);
    check("lbu_rdata", rd, 32'h0000009C);
    check("lbu_nbeats", 32'(addr_log.size()), 32'd1);

    // SH on a word port lands in the upper half lanes.
    do_access(2, 1'b1, 3'b001, 32'h7A, 32'h1234ABCD, 0, rd, er, lat);
    check("sh_nbeats", 32'(addr_log.size()), 32'd1);
    if (addr_log.size() > 0) begin
      check("sh_addr", addr_log[0], 32'h78);
      check("sh_strb", 32'(strb_log[0]), 32'hC);
      check("sh_wdata", wd_log[0], 32'hABCD0000);
    end
    check("sh_rdata", rd, 32'h0);

    // Errors: misaligned LW, reserved load funct3, unsigned store encoding.
    do_access(2, 1'b0, 3'b010, 32'h82, 32'h0, 0, rd, er, lat);
    check("lw_misaligned_err", 32'(er), 32'h1);
    check("lw_misaligned_beats", 32'(addr_log.size()), 32'd0);
    do_access(2, 1'b0, 3'b011, 32'h80, 32'h0, 0, rd, er, lat);
    check("f3_011_err", 32'(er), 32'h1);
    check("f3_011_lat", 32'(lat), 32'd1);
    do_access(1, 1'b1, 3'b100, 32'h20, 32'h55, 0, rd, er, lat);
    check("sbu_err", 32'(er), 32'h1);
    do_access(1, 1'b0, 3'b001, 32'h11, 32'h0, 0, rd, er, lat);
    check("lh_misaligned_err", 32'(er), 32'h1);

    // Halfword port with a three-cycle stall on the only beat.
    do_access(1, 1'b0, 3'b001, 32'h10, 32'h0, 3, rd, er, lat);
    check("lh_stall_rdata", rd, 32'hFFFF8001);
    check("lh_stall_lat", 32'(lat), 32'd5);
    do_access(1, 1'b0, 3'b101, 32'h10, 32'h0, 0, rd, er, lat);
    check("lhu_rdata", rd, 32'h00008001);

    // Word store over a halfword port: two beats.
    do_access(1, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 0, rd, er, lat);
    check("sw_b2_nbeats", 32'(addr_log.size()), 32'd2);
    if (wd_log.size() == 2) begin
      check("sw_b2_wd0", wd_log[0], 32'h0000BEEF);
      check("sw_b2_wd1", wd_log[1], 32'h0000DEAD);
    end

    // Byte store, then byte and word loads on the word port.
    do_access(0, 1'b1, 3'b000, 32'h05, 32'h12345681, 1, rd, er, lat);
    if (wd_log.size() > 0) check("sb_wdata", wd_log[0], 32'h00000081);
    mem[8'h83] = 8'h7F;
    do_access(2, 1'b0, 3'b000, 32'h83, 32'h0, 0, rd, er, lat);
    check("lb_lane3", rd, 32'h0000007F);
    do_access(2, 1'b0, 3'b010, 32'h80, 32'h0, 2, rd, er, lat);
    check("lw_b4_rdata", rd, 32'h7F009C58);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
